hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core (add/sub/ori/lw/sw/lui/beq/j).
- Drives PC/IF-ID write enables and Control_Write (0 = ID decoder emits a bubble).
- Drives IF/EX flush requests, and freezes the whole pipeline while a data-memory access waits for its acknowledge.
- Sits beside the ID-stage control unit and takes hazard inputs from the ID, EX and MEM stages.

Parameters:
MEM_TIMEOUT, 15, maximum number of consecutive unacknowledged mem_req cycles before the error state (legal 1..255).
CNT_W, 16, width of the stall statistics counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt (add/sub/beq/sw)
ex_memread  in  1  EX instruction is lw
ex_rt  in  5  destination rt of the EX instruction
ex_branch_taken  in  1  beq in EX resolved taken
id_jump  in  1  ID instruction is j
mem_req  in  1  MEM stage issues a data-memory access (lw/sw)
mem_ack  in  1  data memory completes the access this cycle
PC_Write  out  1  PC update enable
IFID_Write  out  1  IF/ID register write enable
Control_Write  out  1  0 = insert bubble into ID/EX
IF_Flush  out  1  active-high: squash the IF/ID contents
EX_Flush  out  1  active-high: squash the ID/EX contents
MEM_Hold  out  1  freeze EX/MEM and MEM/WB
mem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  cycles with PC_Write=0 since reset

Behaviour:
- States: RUN, MEM_WAIT, ERR. Reset → RUN.
- Outputs are combinational from state and inputs. wait_cnt is 8 bits.
- While rst_n=0, all outputs are 0, including stall_cnt and wait_cnt.
- memstall = mem_req & ~mem_ack.
- loaduse = ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).

RUN priority (highest first):
- memstall: PC_Write=IFID_Write=Control_Write=0, MEM_Hold=1, no flushes. Next state MEM_WAIT with wait_cnt=1. If MEM_TIMEOUT==1, next state is ERR instead.
- ex_branch_taken: IF_Flush=EX_Flush=1; PC_Write=IFID_Write=Control_Write=1. Any loaduse is ignored because the ID instruction is squashed.
- loaduse: PC_Write=IFID_Write=Control_Write=0 for exactly 1 cycle, then the lw leaves EX and the hazard clears naturally. A simultaneous id_jump is not flushed this cycle; it is re-evaluated next cycle.
- id_jump: IF_Flush=1, EX_Flush=0, enables 1.
- otherwise: enables 1, flushes 0, MEM_Hold=0.

MEM_WAIT:
- Outputs are the same as the RUN memstall row, regardless of branch/loaduse/jump inputs. A pending branch flush is deferred until release.
- mem_ack=1 → RUN at the next edge. The release cycle itself still holds: outputs are frozen in MEM_WAIT.
- mem_ack=0 with wait_cnt==MEM_TIMEOUT-1 → ERR. Otherwise wait_cnt increments.
- Ack in the same cycle as the final allowed wait: ack wins (→ RUN).

ERR:
- PC_Write=IFID_Write=Control_Write=0, MEM_Hold=1, flushes 0, mem_timeout=1.
- Exit only by reset.

stall_cnt:
- +1 on every edge where PC_Write=0 (rst_n=1); saturates at 2^CNT_W-1.
- Counts ERR cycles too.

Reset mid-stall:
- Asynchronous return to RUN; counters clear immediately.
- The first post-reset cycle evaluates the RUN rules.

Register indices are compared as-is. ex_rt=0 never causes a loaduse.

Test Plan:
- Load-use on rs: ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle → PC_Write/IFID_Write/Control_Write=0 for that cycle, stall_cnt 0→1. With ex_rt=0 instead → no stall.
- Branch taken together with loaduse (ex_branch_taken=1, ex_rt=id_rt=7, id_uses_rt=1) → IF_Flush=EX_Flush=1, enables 1, stall_cnt unchanged. id_jump alone → IF_Flush=1, EX_Flush=0.
- Memory wait: mem_req=1, mem_ack low for 3 cycles then high → MEM_Hold=1 and enables 0 for 4 cycles (RUN plus 3 in MEM_WAIT); RUN on the 5th cycle; stall_cnt=4.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ack=0 held → ERR after the 4th unacked cycle. mem_timeout=1 stays set even after mem_ack=1; rst_n pulse clears it. Repeat with ack on the 4th cycle → RUN, no error.
- Reset mid-MEM_WAIT: rst_n=0 asynchronously → all outputs 0 within the same cycle; after release with no hazards, enables=1.
- Saturation with CNT_W=4: hold ERR for 20 cycles → stall_cnt sticks at 15.

Source files
------------

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard scheduler for the 5-stage MIPS core
//
// Purpose: decides, every cycle, whether the front end advances, whether the
// ID decoder emits a bubble, which stages are squashed, and whether the back
// end is frozen waiting for data memory. A stuck memory access ends in a
// sticky error state that only reset leaves.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt           source registers of the instruction in ID
//   id_uses_rt             ID instruction reads rt (add/sub/beq/sw)
//   ex_memread, ex_rt      EX instruction is lw, and its destination rt
//   ex_branch_taken        beq in EX resolved taken
//   id_jump                ID instruction is j
//   mem_req, mem_ack       MEM stage access request / memory completion
//   PC_Write, IFID_Write   front-end write enables
//   Control_Write          0 = ID decoder emits a bubble into ID/EX
//   IF_Flush, EX_Flush     squash IF/ID, ID/EX contents
//   MEM_Hold               freeze EX/MEM and MEM/WB
//   mem_timeout            sticky memory-timeout error flag
//   stall_cnt              saturating count of cycles with PC_Write=0

module hazard_sched #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             Control_Write,
    output logic             IF_Flush,
    output logic             EX_Flush,
    output logic             MEM_Hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // wait_q holds the number of unacknowledged cycles already spent; the
    // cycle that would make it reach MEM_TIMEOUT goes to ERR instead.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q;

    logic memstall;
    logic loaduse;
    logic pc_we, ifid_we, ctrl_we, if_fl, ex_fl, hold, tmo;

    assign memstall = mem_req & ~mem_ack;
    // r0 is hard-wired zero, so a lw targeting it never creates a dependency.
    assign loaduse  = ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_comb begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        ctrl_we = 1'b1;
        if_fl   = 1'b0;
        ex_fl   = 1'b0;
        hold    = 1'b0;
        tmo     = 1'b0;
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (memstall) begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    ctrl_we = 1'b0;
                    hold    = 1'b1;
                    wait_d  = 8'd1;
                    state_d = (MEM_TIMEOUT == 1) ? ERR : MEM_WAIT;
                end else if (ex_branch_taken) begin
                    // The ID instruction is squashed, so a load-use on it is moot.
                    if_fl = 1'b1;
                    ex_fl = 1'b1;
                end else if (loaduse) begin
                    // Jump in ID waits; it is seen again once the bubble passes.
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    ctrl_we = 1'b0;
                end else if (id_jump) begin
                    if_fl = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Frozen even in the ack cycle; branch flushes wait for RUN.
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                ctrl_we = 1'b0;
                hold    = 1'b1;
                if (mem_ack) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == LAST_WAIT) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ERR: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                ctrl_we = 1'b0;
                hold    = 1'b1;
                tmo     = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of state.
    assign PC_Write      = rst_n & pc_we;
    assign IFID_Write    = rst_n & ifid_we;
    assign Control_Write = rst_n & ctrl_we;
    assign IF_Flush      = rst_n & if_fl;
    assign EX_Flush      = rst_n & ex_fl;
    assign MEM_Hold      = rst_n & hold;
    assign mem_timeout   = rst_n & tmo;
    assign stall_cnt     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!pc_we && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched

module tb_hazard_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, ex_branch_taken, id_jump, mem_req, mem_ack;

    logic       pc_w, ifid_w, ctrl_w, if_fl, ex_fl, mem_hold, mem_to;
    logic [3:0] scnt;
    logic       d1_pc, d1_ifid, d1_ctrl, d1_iff, d1_exf, d1_hold, d1_to;
    logic [15:0] d1_cnt;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    hazard_sched #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .mem_req(mem_req), .mem_ack(mem_ack),
        .PC_Write(pc_w), .IFID_Write(ifid_w), .Control_Write(ctrl_w),
        .IF_Flush(if_fl), .EX_Flush(ex_fl), .MEM_Hold(mem_hold),
        .mem_timeout(mem_to), .stall_cnt(scnt)
    );

    hazard_sched #(.MEM_TIMEOUT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .mem_req(mem_req), .mem_ack(mem_ack),
        .PC_Write(d1_pc), .IFID_Write(d1_ifid), .Control_Write(d1_ctrl),
        .IF_Flush(d1_iff), .EX_Flush(d1_exf), .MEM_Hold(d1_hold),
        .mem_timeout(d1_to), .stall_cnt(d1_cnt)
    );

    function automatic logic [10:0] obs();
        return {pc_w, ifid_w, ctrl_w, if_fl, ex_fl, mem_hold, mem_to, scnt};
    endfunction

    function automatic logic [6:0] obs1();
        return {d1_pc, d1_ifid, d1_ctrl, d1_iff, d1_exf, d1_hold, d1_to};
    endfunction

    function automatic logic [20:0] st(input int rs, input int rt, input bit uses,
                                       input bit memrd, input int exrt, input bit br,
                                       input bit jmp, input bit req, input bit ack);
        return {5'(rs), 5'(rt), uses, memrd, 5'(exrt), br, jmp, req, ack};
    endfunction

    function automatic logic [10:0] ex(input logic [2:0] en, input logic [1:0] fl,
                                       input bit hold, input bit tmo, input int cnt);
        return {en, fl, hold, tmo, 4'(cnt)};
    endfunction

    task automatic apply(input logic [20:0] s);
        {id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, id_jump, mem_req, mem_ack} = s;
    endtask

    task automatic do_reset();
        apply('0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] got, want;
        rst_n = 1'b0;
        apply(st(0, 0, 0, 0, 0, 1, 1, 1, 0));
        #3;
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected %b", obs(), 11'd0);
        end
        checks++;
        if (obs1() !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs_t1 got %b expected %b", obs1(), 7'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply('0);
        sb.push_back(ex(3'b111, 2'b00, 0, 0, 0));
        @(negedge clk);
        got = obs(); want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_idle got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loaduse();
        logic [20:0] s[6];
        logic [10:0] e[6];
        logic [10:0] got, want;
        do_reset();
        s[0] = st(5, 0, 0, 1, 5, 0, 0, 0, 0); e[0] = ex(3'b000, 2'b00, 0, 0, 0);
        s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0); e[1] = ex(3'b111, 2'b00, 0, 0, 1);
        s[2] = st(0, 0, 1, 1, 0, 0, 0, 0, 0); e[2] = ex(3'b111, 2'b00, 0, 0, 1);
        s[3] = st(3, 7, 0, 1, 7, 0, 0, 0, 0); e[3] = ex(3'b111, 2'b00, 0, 0, 1);
        s[4] = st(3, 7, 1, 1, 7, 0, 1, 0, 0); e[4] = ex(3'b000, 2'b00, 0, 0, 1);
        s[5] = st(0, 0, 0, 0, 0, 0, 1, 0, 0); e[5] = ex(3'b111, 2'b10, 0, 0, 2);
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got = obs(); want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL loaduse[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [20:0] s[4];
        logic [10:0] e[4];
        logic [10:0] got, want;
        do_reset();
        s[0] = st(0, 7, 1, 1, 7, 1, 0, 0, 0); e[0] = ex(3'b111, 2'b11, 0, 0, 0);
        s[1] = st(0, 0, 0, 0, 0, 0, 1, 0, 0); e[1] = ex(3'b111, 2'b10, 0, 0, 0);
        s[2] = st(0, 0, 0, 0, 0, 1, 1, 0, 0); e[2] = ex(3'b111, 2'b11, 0, 0, 0);
        s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = ex(3'b111, 2'b00, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got = obs(); want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch_jump[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // Ack arrives on the fourth cycle, exactly the last allowed wait: ack must win.
    task automatic test_mem_wait();
        logic [20:0] s[5];
        logic [10:0] e[5];
        logic [10:0] got, want;
        do_reset();
        s[0] = st(0, 0, 0, 0, 0, 0, 0, 1, 0); e[0] = ex(3'b000, 2'b00, 1, 0, 0);
        s[1] = st(0, 0, 0, 0, 0, 1, 0, 1, 0); e[1] = ex(3'b000, 2'b00, 1, 0, 1);
        s[2] = st(5, 0, 0, 1, 5, 0, 1, 1, 0); e[2] = ex(3'b000, 2'b00, 1, 0, 2);
        s[3] = st(0, 0, 0, 0, 0, 1, 0, 1, 1); e[3] = ex(3'b000, 2'b00, 1, 0, 3);
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = ex(3'b111, 2'b00, 0, 0, 4);
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got = obs(); want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mem_wait[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [20:0] s[6];
        logic [10:0] e[6];
        logic [10:0] got, want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s[i] = st(0, 0, 0, 0, 0, 0, 0, 1, 0);
            e[i] = ex(3'b000, 2'b00, 1, 0, i);
        end
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 1, 1); e[4] = ex(3'b000, 2'b00, 1, 1, 4);
        s[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = ex(3'b000, 2'b00, 1, 1, 5);
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got = obs(); want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout[%0d] got %b expected %b", i, got, want);
            end
            checks++;
            if (d1_to !== (i >= 1)) begin
                errors++;
                $display("FAIL timeout_t1[%0d] got %b expected %b", i, d1_to, (i >= 1));
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL timeout_reset got %b expected %b", obs(), 11'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply('0);
        sb.push_back(ex(3'b111, 2'b00, 0, 0, 0));
        @(negedge clk);
        got = obs(); want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL timeout_cleared got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        logic [10:0] got, want;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0));
            sb.push_back(ex(3'b000, 2'b00, 1, 0, i));
            @(negedge clk);
            got = obs(); want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_stall[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL mid_stall_async got %b expected %b", obs(), 11'd0);
        end
        checks++;
        if (obs1() !== 7'd0) begin
            errors++;
            $display("FAIL mid_stall_async_t1 got %b expected %b", obs1(), 7'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply('0);
        sb.push_back(ex(3'b111, 2'b00, 0, 0, 0));
        @(negedge clk);
        got = obs(); want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL mid_stall_release got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [10:0] got, want;
        do_reset();
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 24; i++) begin
            sb.push_back(ex(3'b000, 2'b00, 1, (i >= 4), (i > 15) ? 15 : i));
            @(negedge clk);
            got = obs(); want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL saturation[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply('0);
        test_reset();
        test_loaduse();
        test_branch_jump();
        test_mem_wait();
        test_timeout();
        test_reset_mid_stall();
        test_saturation();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
